// File: rtl/jtag_shift_seq.sv
// Sequencer that splits one 1..1023-bit JTAG operation into <=16-bit engine commands.
// Define JTAG_SEQ_READBACK_EN to add the TDO read-back phase (command 5) after each chunk.
module jtag_shift_seq #(
  parameter int DTACK_TMO = 4095
) (
  input  logic        FASTCLK,
  input  logic        RST_B,
  input  logic        START,
  input  logic        TAPRST,
  input  logic        IR,
  input  logic        HEADER,
  input  logic        TAIL,
  input  logic [9:0]  NBITS,
  input  logic [15:0] DIN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        DEVICE,
  output logic [9:0]  COMMAND,
  output logic [15:0] INDATA,
  output logic        STROBE,
  input  logic        DTACK_B,
  input  logic [15:0] OUTDATA
);

  typedef enum logic [3:0] {
    IDLE, WAIT_DIN, S_SETUP, S_ACK, S_REL, R_SETUP, R_ACK, R_REL, OUT, NEXT, DONE_ST, ERR_ST
  } state_t;

  state_t      state, state_nxt;
  logic        dtack_s1, dtack_s2;
  logic [15:0] tmo_cnt;
  logic        err_q;
  logic [9:0]  cmd_q;
  logic [15:0] indata_q;
  logic [9:0]  r_q;
  logic        first_q, hdr_q, tail_q, ir_q, tap_q;
  logic [3:0]  csize_m1;
  logic [4:0]  chunk;
  logic        last_chunk, idle_like, take_start, start_bad, tmo_hit;

  assign csize_m1   = (r_q >= 10'd16) ? 4'd15 : (r_q[3:0] - 4'd1);
  assign chunk      = 5'(csize_m1) + 5'd1;
  assign last_chunk = (r_q == 10'(chunk));
  assign idle_like  = (state == IDLE) || (state == DONE_ST) || (state == ERR_ST);
  assign take_start = START && idle_like;
  assign start_bad  = !TAPRST && ((NBITS == 10'd0) || (IR && (NBITS > 10'd16)));
  assign tmo_hit    = (tmo_cnt == 16'(DTACK_TMO));

  always_comb begin
    state_nxt  = state;
    DIN_READY  = 1'b0;
    STROBE     = 1'b0;
    DEVICE     = 1'b0;
    DOUT_VALID = 1'b0;
    DONE       = 1'b0;
    BUSY       = 1'b1;
    case (state)
      IDLE, DONE_ST, ERR_ST: begin
        BUSY      = 1'b0;
        DONE      = (state == DONE_ST);
        state_nxt = IDLE;
        if (START) begin
          if (TAPRST)         state_nxt = S_SETUP;
          else if (!start_bad) state_nxt = WAIT_DIN;
        end
      end
      WAIT_DIN: begin
        DIN_READY = 1'b1;
        if (DIN_VALID) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        DEVICE    = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        DEVICE = 1'b1;
        STROBE = 1'b1;
        if (!dtack_s2)    state_nxt = S_REL;
        else if (tmo_hit) state_nxt = ERR_ST;
      end
      S_REL: begin
        DEVICE = 1'b1;
        if (dtack_s2) begin
`ifdef JTAG_SEQ_READBACK_EN
          state_nxt = tap_q ? DONE_ST : R_SETUP;
`else
          state_nxt = tap_q ? DONE_ST : NEXT;
`endif
        end else if (tmo_hit) begin
          state_nxt = ERR_ST;
        end
      end
`ifdef JTAG_SEQ_READBACK_EN
      R_SETUP: begin
        DEVICE    = 1'b1;
        state_nxt = R_ACK;
      end
      R_ACK: begin
        DEVICE = 1'b1;
        STROBE = 1'b1;
        if (!dtack_s2)    state_nxt = R_REL;
        else if (tmo_hit) state_nxt = ERR_ST;
      end
      R_REL: begin
        DEVICE = 1'b1;
        if (dtack_s2)     state_nxt = OUT;
        else if (tmo_hit) state_nxt = ERR_ST;
      end
      OUT: begin
        DOUT_VALID = 1'b1;
        state_nxt  = NEXT;
      end
`endif
      NEXT:    state_nxt = last_chunk ? DONE_ST : WAIT_DIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers and engine-facing outputs
  always_ff @(posedge FASTCLK) begin
    if (!RST_B) begin
      state    <= IDLE;
      dtack_s1 <= 1'b1;
      dtack_s2 <= 1'b1;
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
      cmd_q    <= '0;
      indata_q <= '0;
    end else begin
      state    <= state_nxt;
      dtack_s1 <= DTACK_B;
      dtack_s2 <= dtack_s1;
      // Restarting on every state change gives each ACK/REL phase its own budget
      tmo_cnt  <= (state_nxt != state) ? 16'd0 : tmo_cnt + 16'd1;
      if (take_start) begin
        err_q <= start_bad;
        if (TAPRST) cmd_q <= 10'd6;
      end
      if (state_nxt == ERR_ST) err_q <= 1'b1;
      if (state == WAIT_DIN && DIN_VALID) begin
        indata_q <= DIN;
        cmd_q    <= ir_q ? {csize_m1, 6'd7}
                         : {csize_m1, 4'b0000, tail_q & last_chunk, hdr_q & first_q};
      end
`ifdef JTAG_SEQ_READBACK_EN
      if (state == S_REL && dtack_s2 && !tap_q) cmd_q <= 10'd5;
`endif
    end
  end

  // Operation descriptor, reloaded by every accepted START
  always_ff @(posedge FASTCLK) begin
    if (take_start) begin
      r_q     <= NBITS;
      first_q <= 1'b1;
      hdr_q   <= HEADER;
      tail_q  <= TAIL;
      ir_q    <= IR;
      tap_q   <= TAPRST;
    end else if (state == NEXT) begin
      r_q     <= r_q - 10'(chunk);
      first_q <= 1'b0;
    end
  end

`ifdef JTAG_SEQ_READBACK_EN
  logic [15:0] dout_q;
  // The engine fills its TDO register from the MSB, so a short chunk sits at the top
  always_ff @(posedge FASTCLK) begin
    if (!RST_B)                           dout_q <= '0;
    else if (state == R_ACK && !dtack_s2) dout_q <= OUTDATA >> (5'd16 - chunk);
  end
  assign DOUT = dout_q;
`else
  logic unused_outdata;
  assign unused_outdata = ^OUTDATA;
  assign DOUT = '0;
`endif

  assign ERR     = err_q;
  assign COMMAND = cmd_q;
  assign INDATA  = indata_q;

endmodule
